// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared definitions for the player motion controller:
//   - motion_state_e : controller state encoding (idle / run left / run right)
//   - default speed-tier constants
//   - tier_sel()     : maps the current stack height to the maximum step size
// -----------------------------------------------------------------------------
package player_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRunL = 2'd1,
    StRunR = 2'd2
  } motion_state_e;

  // Default maximum step per move tick for each stack-height tier.
  localparam int unsigned DefSpdFast   = 6;
  localparam int unsigned DefSpdNormal = 4;
  localparam int unsigned DefSpdSlow   = 2;

  // A taller stack makes the player slower. The tier boundaries are inclusive:
  // exactly one box height still counts as the fast tier.
  function automatic int unsigned tier_sel(input logic [9:0]  height,
                                           input int unsigned base_height,
                                           input int unsigned spd_fast,
                                           input int unsigned spd_normal,
                                           input int unsigned spd_slow);
    int unsigned h;
    h = 32'(height);
    if (h <= base_height) begin
      return spd_fast;
    end else if (h <= 2 * base_height) begin
      return spd_normal;
    end else begin
      return spd_slow;
    end
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// -----------------------------------------------------------------------------
// move_tick_gen
// Divides enabled clock cycles into move ticks. The counter runs
// 0..TICK_DIV-1 only while en is high and freezes otherwise, so pausing the
// game never shortens or lengthens the tick in progress.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   en    in   count enable (game running)
//   tick  out  one-cycle pulse on the last enabled cycle of each period
// -----------------------------------------------------------------------------
module move_tick_gen #(
  parameter int unsigned TICK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // Keep at least one counter bit so TICK_DIV == 1 still elaborates cleanly;
  // in that case the counter stays at zero and every enabled cycle ticks.
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] tick_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (en) begin
      if (tick_cnt == CntMax) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CntW'(1);
      end
    end
  end

  assign tick = en && (tick_cnt == CntMax);

endmodule

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Horizontal motion controller for the player box. Decodes the debounced
// active-low buttons once per move tick, picks a step size from the stack
// height tier and moves box_x, saturating at both screen walls.
//
// Optional feature (compile-time macro PLAYER_ACCEL_EN):
//   defined   -> acceleration ramp: step starts at 1 and grows by 1 per tick
//                while the direction is held, capped at the current tier max.
//   undefined -> every moving tick uses the full tier max step.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-low reset
//   game_en         in   1 = advance, 0 = freeze all state
//   buttons[1:0]    in   active-low; [0] = right, [1] = left
//   current_height  in   stack height in pixels, sampled on tick
//   box_x           out  left edge of the player box
//   moving          out  controller is in a run state
//   dir_right       out  direction of the last move (1 = right)
//   cur_step        out  step applied on the last tick
//   at_wall_l       out  box_x is at the left wall
//   at_wall_r       out  box_x is at the right limit
// -----------------------------------------------------------------------------
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int unsigned X_W         = 10,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned BOX_WIDTH   = 30,
  parameter int unsigned BASE_HEIGHT = 30,
  parameter int unsigned X_INIT      = 50,
  parameter int unsigned TICK_DIV    = 2,
  parameter int unsigned STEP_W      = 4,
  parameter int unsigned SPD_FAST    = DefSpdFast,
  parameter int unsigned SPD_NORMAL  = DefSpdNormal,
  parameter int unsigned SPD_SLOW    = DefSpdSlow
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_en,
  input  logic [1:0]        buttons,
  input  logic [9:0]        current_height,
  output logic [X_W-1:0]    box_x,
  output logic              moving,
  output logic              dir_right,
  output logic [STEP_W-1:0] cur_step,
  output logic              at_wall_l,
  output logic              at_wall_r
);

  localparam int unsigned      RightLimit    = SCREEN_W - BOX_WIDTH;
  // Position math is one bit wider than box_x so box_x + step cannot wrap.
  localparam logic [X_W:0]     RightLimitExt = (X_W + 1)'(RightLimit);
  localparam logic [X_W-1:0]   XInit         = X_W'(X_INIT);

  motion_state_e     state;
  motion_state_e     state_next;
  logic              tick;
  logic              go_r;
  logic              go_l;
  logic [STEP_W-1:0] tier_max;
  logic [STEP_W-1:0] step_next;
  logic [X_W:0]      pos_ext;
  logic [X_W:0]      step_ext;
  logic [X_W:0]      sum_ext;
  logic [X_W:0]      x_next;

  move_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_move_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (game_en),
    .tick (tick)
  );

  // Direction decode: exactly one button pressed means run; none or both
  // pressed means stand still.
  always_comb begin
    go_r = ~buttons[0];
    go_l = ~buttons[1];
    if (go_r && !go_l) begin
      state_next = StRunR;
    end else if (go_l && !go_r) begin
      state_next = StRunL;
    end else begin
      state_next = StIdle;
    end
  end

  // Step size for the upcoming tick.
  always_comb begin
    tier_max = STEP_W'(tier_sel(current_height, BASE_HEIGHT, SPD_FAST, SPD_NORMAL, SPD_SLOW));
`ifdef PLAYER_ACCEL_EN
    if (state_next == StIdle) begin
      step_next = '0;
    end else if (state_next == state) begin
      // Same direction as last tick: ramp up by one, clamped to the tier.
      // The >= also clamps when the tier dropped below the previous step.
      step_next = (cur_step >= tier_max) ? tier_max : cur_step + STEP_W'(1);
    end else begin
      // Start from standstill or a reversal.
      step_next = STEP_W'(1);
    end
`else
    step_next = (state_next == StIdle) ? '0 : tier_max;
`endif
  end

  // Next position with saturation at both walls; a move is never refused,
  // it is shortened to land exactly on the wall.
  always_comb begin
    pos_ext  = {1'b0, box_x};
    step_ext = (X_W + 1)'(step_next);
    sum_ext  = pos_ext + step_ext;
    x_next   = pos_ext;
    case (state_next)
      StRunR:  x_next = (sum_ext > RightLimitExt) ? RightLimitExt : sum_ext;
      StRunL:  x_next = (pos_ext < step_ext) ? '0 : pos_ext - step_ext;
      default: x_next = pos_ext;
    endcase
  end

  // Single state register; everything changes only on a move tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      box_x     <= XInit;
      cur_step  <= '0;
      dir_right <= 1'b1;
    end else if (tick) begin
      state    <= state_next;
      box_x    <= x_next[X_W-1:0];
      cur_step <= step_next;
      // Idle ticks keep the last direction so the renderer can face the box.
      if (state_next == StRunR) begin
        dir_right <= 1'b1;
      end else if (state_next == StRunL) begin
        dir_right <= 1'b0;
      end
    end
  end

  assign moving    = (state != StIdle);
  assign at_wall_l = (box_x == '0);
  assign at_wall_r = ({1'b0, box_x} == RightLimitExt);

endmodule
